// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory controller.
//   SZ_*       : req_size encodings
//   state_t    : controller FSM states
//   LATENCY_W  : width of the wait-state down-counter
package dmem_pkg;

  localparam int LATENCY_W = 4;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_RSVD = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for the data-memory controller (purely combinational).
// Ports:
//   size, offset, is_unsigned : access size, byte offset addr[1:0], load extension
//   wdata      : right-aligned store data
//   rword      : raw RAM word for loads
//   wmask      : per-byte store enable
//   wdata_lane : store data replicated onto the lanes
//   rdata_ext  : shifted and sign/zero-extended load data
//   misalign   : half on odd address, or word not word-aligned
//   size_rsvd  : reserved size encoding used
module dmem_lane_align
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [1:0]              size,
  input  logic [1:0]              offset,
  input  logic                    is_unsigned,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH-1:0]   rword,
  output logic [DATA_WIDTH/8-1:0] wmask,
  output logic [DATA_WIDTH-1:0]   wdata_lane,
  output logic [DATA_WIDTH-1:0]   rdata_ext,
  output logic                    misalign,
  output logic                    size_rsvd
);

  localparam int NB = DATA_WIDTH / 8;

  logic [1:0]            eff_off;
  logic [DATA_WIDTH-1:0] shifted;

  // Misaligned low address bits are dropped here; whether that is an error is
  // decided by the controller.
  always_comb begin
    eff_off    = 2'b00;
    wmask      = '1;
    wdata_lane = wdata;
    misalign   = 1'b0;
    size_rsvd  = 1'b0;
    case (size)
      SZ_BYTE: begin
        eff_off    = offset;
        wmask      = NB'(1) << offset;
        wdata_lane = {NB{wdata[7:0]}};
      end
      SZ_HALF: begin
        eff_off    = {offset[1], 1'b0};
        wmask      = NB'(3) << {offset[1], 1'b0};
        wdata_lane = {(NB/2){wdata[15:0]}};
        misalign   = offset[0];
      end
      SZ_WORD: begin
        misalign = |offset;
      end
      default: begin
        size_rsvd = 1'b1;
      end
    endcase
  end

  always_comb begin
    shifted   = rword >> {eff_off, 3'b000};
    rdata_ext = shifted;
    case (size)
      SZ_BYTE: rdata_ext = {{(DATA_WIDTH-8){~is_unsigned & shifted[7]}}, shifted[7:0]};
      SZ_HALF: rdata_ext = {{(DATA_WIDTH-16){~is_unsigned & shifted[15]}}, shifted[15:0]};
      default: rdata_ext = shifted;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: valid/ready request/response front end for an
// on-chip 32-bit RAM with programmable wait states and byte/half/word access.
// Optional macro DMEM_ACCESS_CHECK_EN enables misalign / reserved-size /
// out-of-range error reporting on rsp_err; without it rsp_err is tied 0 and
// addresses wrap modulo the RAM depth.
// Ports:
//   clk, resetn                  : clock, asynchronous active-low reset
//   req_valid/req_ready          : request handshake
//   req_we, req_size, req_unsigned, req_addr, req_wdata : request fields
//   rsp_valid/rsp_ready          : response handshake
//   rsp_rdata, rsp_err           : response payload
//
// state   | meaning
// IDLE    | ready for a request; stores commit on the accepting edge
// WAIT    | counting down wait states
// RESP    | response held until rsp_ready
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 1,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [31:0]           req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [LATENCY_W-1:0] LAT_INIT = LATENCY_W'(LATENCY);

  state_t                 state_q, state_d;
  logic [LATENCY_W-1:0]   cnt_q, cnt_d;
  logic                   we_q, uns_q, err_q;
  logic [1:0]             size_q, off_q;
  logic [ADDR_WIDTH-1:0]  idx_q;
  logic [DATA_WIDTH-1:0]  mem [DEPTH];

  logic                   accept;
  logic                   acc_err;
  logic [ADDR_WIDTH-1:0]  req_idx;
  logic [1:0]             al_size, al_off;
  logic                   al_uns;
  logic [NB-1:0]          wmask;
  logic [DATA_WIDTH-1:0]  wdata_lane, rdata_ext;
  logic                   misalign, size_rsvd;

  assign req_ready = (state_q == ST_IDLE);
  assign accept    = req_valid && req_ready;
  assign req_idx   = req_addr[ADDR_WIDTH+1:2];

  // One aligner serves both paths: in IDLE it decodes the incoming request
  // (store lanes, error flags); afterwards the latched fields drive the load path.
  assign al_size = req_ready ? req_size     : size_q;
  assign al_off  = req_ready ? req_addr[1:0] : off_q;
  assign al_uns  = req_ready ? req_unsigned : uns_q;

  dmem_lane_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .size        (al_size),
    .offset      (al_off),
    .is_unsigned (al_uns),
    .wdata       (req_wdata),
    .rword       (mem[idx_q]),
    .wmask       (wmask),
    .wdata_lane  (wdata_lane),
    .rdata_ext   (rdata_ext),
    .misalign    (misalign),
    .size_rsvd   (size_rsvd)
  );

`ifdef DMEM_ACCESS_CHECK_EN
  assign acc_err = misalign | size_rsvd | (|req_addr[31:ADDR_WIDTH+2]);
`else
  logic unused_chk;
  assign acc_err    = 1'b0;
  assign unused_chk = ^{misalign, size_rsvd, req_addr[31:ADDR_WIDTH+2]};
`endif

  // RAM is never cleared; a store presented while reset is held does not commit.
  always_ff @(posedge clk) begin
    if (accept && resetn && req_we && !acc_err) begin
      for (int b = 0; b < NB; b++) begin
        if (wmask[b]) mem[req_idx][8*b +: 8] <= wdata_lane[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= SZ_BYTE;
      off_q   <= 2'b00;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q   <= req_we;
        uns_q  <= req_unsigned;
        err_q  <= acc_err;
        size_q <= req_size;
        off_q  <= req_addr[1:0];
        idx_q  <= req_idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (LATENCY == 0) begin
            state_d = ST_RESP;
          end else begin
            cnt_d   = LAT_INIT;
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == LATENCY_W'(1)) state_d = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_err   = rsp_valid & err_q;
  assign rsp_rdata = (rsp_valid && !we_q && !err_q) ? rdata_ext : '0;

endmodule

// File: tb/tb_dmem_ctrl.sv
module tb_dmem_ctrl;
  localparam int AW    = 10;
  localparam int LAT   = 2;
  localparam int DW    = 32;
  localparam int BYTES = 4 * (2 ** AW);

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [1:0]    req_size = 2'd0;
  logic          req_unsigned = 1'b0;
  logic [31:0]   req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;

  int checks = 0;
  int errors = 0;
  logic [7:0] ref_mem [BYTES];

  always #5 clk = ~clk;

  dmem_ctrl #(.ADDR_WIDTH(AW), .LATENCY(LAT), .DATA_WIDTH(DW)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Byte-array reference: applies a request and returns the expected response.
  task automatic model(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd,
                       output logic [31:0] d, output logic e);
    int unsigned ba;
    int nb;
    nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
`ifdef DMEM_ACCESS_CHECK_EN
    e = (sz == 2'd3) || (sz == 2'd1 && addr[0]) || (sz == 2'd2 && addr[1:0] != 2'b00) ||
        (addr >= 32'(BYTES));
`else
    e = 1'b0;
`endif
    ba = addr % BYTES;
    ba = ba - (ba % nb);
    d  = '0;
    if (!e) begin
      if (we) begin
        for (int i = 0; i < nb; i++) ref_mem[ba + i] = wd[8*i +: 8];
      end else begin
        for (int i = 0; i < nb; i++) d = d | (32'(ref_mem[ba + i]) << (8 * i));
        if (nb < 4 && !uns && d[8*nb-1]) d = d | (32'hFFFF_FFFF << (8 * nb));
      end
    end
  endtask

  task automatic drive(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd);
    req_we       = we;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wd;
    req_valid    = 1'b1;
  endtask

  // Full transaction starting at a negedge; checks latency and payload against
  // the model and returns what was observed.
  task automatic xact(input logic we, input logic [1:0] sz, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wd, input string tag,
                      output logic [31:0] got_d, output logic got_e);
    logic [31:0] exp_d;
    logic        exp_e;
    int k;
    got_d = '0;
    got_e = 1'b0;
    model(we, sz, uns, addr, wd, exp_d, exp_e);
    drive(we, sz, uns, addr, wd);
    k = 0;
    while (!req_ready && k < 50) begin @(negedge clk); k++; end
    if (k >= 50) begin chk({tag, "_accept_timeout"}, 32'(k), 32'd0); req_valid = 1'b0; return; end
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    k = 0;
    while (!rsp_valid && k < 40) begin @(negedge clk); k++; end
    chk({tag, "_latency"}, 32'(k), 32'(LAT));
    if (k >= 40) return;
    got_d = rsp_rdata;
    got_e = rsp_err;
    chk({tag, "_rdata"}, rsp_rdata, exp_d);
    chk({tag, "_err"}, 32'(rsp_err), 32'(exp_e));
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d, held, exp_d;
    logic        e, exp_e;
    int k;

    for (int i = 0; i < BYTES; i++) ref_mem[i] = 8'h00;

    // reset state
    #2;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    // word store / load
    xact(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, "st_w10", d, e);
    chk("st_w10_zero_rdata", d, 32'd0);
    xact(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, "ld_w10", d, e);
    chk("ld_w10_lit", d, 32'hDEADBEEF);

    // byte store, signed/unsigned loads
    xact(1'b1, 2'd0, 1'b0, 32'h11, 32'h80, "st_b11", d, e);
    xact(1'b0, 2'd0, 1'b0, 32'h11, 32'h0, "ld_b11_s", d, e);
    chk("ld_b11_s_lit", d, 32'hFFFFFF80);
    xact(1'b0, 2'd0, 1'b1, 32'h11, 32'h0, "ld_b11_u", d, e);
    chk("ld_b11_u_lit", d, 32'h00000080);
    xact(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, "ld_w10b", d, e);
    chk("ld_w10b_lit", d, 32'hDEAD80EF);

    // half store, signed/unsigned loads
    xact(1'b1, 2'd1, 1'b0, 32'h22, 32'h8001, "st_h22", d, e);
    xact(1'b0, 2'd1, 1'b0, 32'h22, 32'h0, "ld_h22_s", d, e);
    chk("ld_h22_s_lit", d, 32'hFFFF8001);
    xact(1'b0, 2'd1, 1'b1, 32'h22, 32'h0, "ld_h22_u", d, e);
    chk("ld_h22_u_lit", d, 32'h00008001);

    // response back-pressure with a second request waiting
    rsp_ready = 1'b0;
    model(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, exp_d, exp_e);
    drive(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    @(posedge clk);
    #1 drive(1'b0, 2'd0, 1'b1, 32'h11, 32'h0);
    @(negedge clk);
    k = 0;
    while (!rsp_valid && k < 40) begin @(negedge clk); k++; end
    chk("stall_latency", 32'(k), 32'(LAT));
    held = rsp_rdata;
    chk("stall_rdata", held, exp_d);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("stall_valid_%0d", i), 32'(rsp_valid), 32'd1);
      chk($sformatf("stall_hold_%0d", i), rsp_rdata, held);
      chk($sformatf("stall_rdy_%0d", i), 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bubble_valid", 32'(rsp_valid), 32'd0);
    chk("bubble_ready", 32'(req_ready), 32'd1);
    xact(1'b0, 2'd0, 1'b1, 32'h11, 32'h0, "after_stall", d, e);
    chk("after_stall_lit", d, 32'h00000080);

    // reset during WAIT: committed store survives, aborted load never responds
    model(1'b1, 2'd2, 1'b0, 32'h40, 32'h0BADCAFE, exp_d, exp_e);
    drive(1'b1, 2'd2, 1'b0, 32'h40, 32'h0BADCAFE);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("wait_ready", 32'(req_ready), 32'd0);
    resetn = 1'b0;
    #1;
    chk("abort_ready", 32'(req_ready), 32'd1);
    chk("abort_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    drive(1'b0, 2'd2, 1'b0, 32'h40, 32'h0);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    chk("abort2_ready", 32'(req_ready), 32'd1);
    chk("abort2_valid", 32'(rsp_valid), 32'd0);
    resetn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("no_rsp_%0d", i), 32'(rsp_valid), 32'd0);
    end
    xact(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, "ld_w40", d, e);
    chk("ld_w40_lit", d, 32'h0BADCAFE);

    // access-error boundaries
    xact(1'b1, 2'd2, 1'b0, 32'h0, 32'hCAFEF00D, "st_w0", d, e);
    xact(1'b1, 2'd2, 1'b0, 32'h13, 32'h5555AAAA, "st_w13", d, e);
    xact(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, "ld_w10c", d, e);
    xact(1'b0, 2'd2, 1'b0, 32'h1000, 32'h0, "ld_1000", d, e);
`ifdef DMEM_ACCESS_CHECK_EN
    chk("ld_1000_err_lit", 32'(e), 32'd1);
    chk("ld_1000_rdata_lit", d, 32'd0);
`else
    chk("ld_1000_wrap_lit", d, 32'hCAFEF00D);
`endif

    // randomized traffic in a small window, sometimes with high address bits
    for (int i = 0; i < 16; i++)
      xact(1'b1, 2'd2, 1'b0, 32'h100 + 32'(4 * i), $urandom, $sformatf("init_%0d", i), d, e);
    for (int i = 0; i < 150; i++) begin
      logic [31:0] a;
      a = 32'h100 + 32'($urandom_range(0, 63));
      if ($urandom_range(0, 7) == 0) a = a | (32'h1 << $urandom_range(12, 31));
      xact(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           a, $urandom, $sformatf("rnd_%0d", i), d, e);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
